ascii_cell_averager: RTL

//  Upstream stage of the ASCII filter. Reduces the RGB888 stream to one 8-bit mean brightness per 8x8 cell.

---
 rtl/ascii_pkg.sv | 22 ++
 rtl/ascii_cell_ram.sv | 39 +++
 rtl/ascii_cell_averager.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ascii_pkg.sv
// ascii_pkg
//   Shared definitions for the ASCII filter path: cell geometry, the 3-bit
//   glyph level type, the 8-bit luma type and the RGB888 -> luma helper.
//   Used by ascii_cell_averager, ascii_cell_ram and the downstream glyph filter.
package ascii_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 8;

  typedef logic [2:0] ascii_level_t;
  typedef logic [7:0] luma_t;

  // Cheap luma approximation (R + 2G + B) / 4 with a 10-bit intermediate.
  function automatic luma_t rgb_to_luma(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return luma_t'(sum >> 2);
  endfunction

endpackage

// File: rtl/ascii_cell_ram.sv
// ascii_cell_ram
//   Simple dual-port cell memory: one write port and one read port on the
//   same clock. Read-first (a same-address write in the same cycle returns
//   the old word), one-cycle registered read. Contents are not reset.
// Ports
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address (sampled every cycle)
//   rd_data  out registered read data, valid the cycle after rd_addr
module ascii_cell_ram
  import ascii_pkg::*;
#(
  parameter int DEPTH  = 1200,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ascii_cell_averager.sv
// ascii_cell_averager
//   Reduces the RGB888 pixel stream to one mean luma per 8x8 cell, stores the
//   means in a cell RAM and streams out the 3-bit level (mean[7:5]) of the cell
//   under the beam, with coordinates and DE delayed to match (2 cycles).
//   The level shown for a cell is its mean from the previous completed frame.
// Optional feature
//   ASCII_CELL_HYST_EN : when defined, a cell mean is only replaced if it
//   differs from the stored one by more than HYST (first frame always stored).
// Ports
//   clk, reset          pixel clock, synchronous active-high reset
//   x_coord, y_coord    beam position
//   display_enable      active video
//   pixel_r8/g8/b8      frame-buffer colour, qualified by pixel_valid
//   cell_level          level of the current cell (0 when no frame stored yet)
//   out_x/out_y/out_de  inputs delayed by 2 cycles
//   frame_ready         sticky: a full frame of cell means has been written
module ascii_cell_averager
  import ascii_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int HYST  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   x_coord,
  input  logic [9:0]   y_coord,
  input  logic         display_enable,
  input  logic [7:0]   pixel_r8,
  input  logic [7:0]   pixel_g8,
  input  logic [7:0]   pixel_b8,
  input  logic         pixel_valid,
  output ascii_level_t cell_level,
  output logic [9:0]   out_x,
  output logic [9:0]   out_y,
  output logic         out_de,
  output logic         frame_ready
);

  localparam int CELLS_X = IMG_W / CELL_W;
  localparam int CELLS_Y = IMG_H / CELL_H;
  localparam int DEPTH   = CELLS_X * CELLS_Y;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CX_W    = $clog2(CELLS_X);

  localparam logic [9:0]  IMG_W_C   = 10'(IMG_W);
  localparam logic [9:0]  IMG_H_C   = 10'(IMG_H);
  localparam logic [13:0] DEPTH_C   = 14'(DEPTH);
  localparam logic [6:0]  LAST_CX_C = 7'(CELLS_X - 1);
  localparam logic [6:0]  LAST_CY_C = 7'(CELLS_Y - 1);

  // cy * CELLS_X + cx built from shifted copies of cy, one per set bit of
  // CELLS_X, so no multiplier is inferred.
  function automatic logic [13:0] cell_addr(input logic [6:0] cx, input logic [6:0] cy);
    logic [13:0] sum;
    sum = {7'd0, cx};
    for (int k = 0; k < 7; k++) begin
      if (CELLS_X[k]) begin
        sum = sum + ({7'd0, cy} << k);
      end
    end
    return sum;
  endfunction

  // ---------------- stage 0 (combinational, from inputs) ----------------
  logic              in_img_s0;
  logic [6:0]        cx_s0;
  logic [6:0]        cy_s0;
  logic [13:0]       addr_full_s0;
  logic [ADDR_W-1:0] rd_addr_d;

  logic              count_d, cell_end_d, last_cell_d, de_d;
  luma_t             luma_d;
  logic [9:0]        x_d, y_d;
  logic [CX_W-1:0]   cx_d;

  always_comb begin
    in_img_s0    = (x_coord < IMG_W_C) && (y_coord < IMG_H_C);
    cx_s0        = x_coord[9:3];
    cy_s0        = y_coord[9:3];
    addr_full_s0 = cell_addr(cx_s0, cy_s0);
    // Out-of-image beams read cell 0; their level is never meaningful.
    rd_addr_d    = (in_img_s0 && (addr_full_s0 < DEPTH_C)) ? addr_full_s0[ADDR_W-1:0] : '0;

    count_d      = display_enable && pixel_valid && in_img_s0;
    cell_end_d   = (x_coord[2:0] == 3'b111) && (y_coord[2:0] == 3'b111);
    last_cell_d  = cell_end_d && (cx_s0 == LAST_CX_C) && (cy_s0 == LAST_CY_C);
    luma_d       = rgb_to_luma(pixel_r8, pixel_g8, pixel_b8);
    x_d          = x_coord;
    y_d          = y_coord;
    de_d         = display_enable;
    cx_d         = x_coord[3 +: CX_W];
  end

  // ---------------- stage 1 registers ----------------
  logic              count_q, cell_end_q, last_cell_q, de_q;
  luma_t             luma_q;
  logic [9:0]        x_q, y_q;
  logic [CX_W-1:0]   cx_q;
  logic [ADDR_W-1:0] addr_q;

  // Per-column running sums for the current cell row.
  logic [13:0] acc_q [CELLS_X];
  logic [13:0] acc_d [CELLS_X];

  // ---------------- stage 2 (combinational, from stage 1) ----------------
  logic [7:0]   rd_data;     // old mean of the stage-1 cell
  logic [13:0]  acc_sum_d;
  luma_t        new_mean_d;
  logic         take_d;
  logic         wr_en_d;
  logic         frame_ready_d;
  ascii_level_t cell_level_d;

  ascii_level_t cell_level_q;
  logic [9:0]   out_x_q, out_y_q;
  logic         out_de_q, frame_ready_q;

  always_comb begin
    acc_sum_d  = acc_q[cx_q] + {6'd0, luma_q};
    // Always divide by 64: missing pixels of a cell count as black.
    new_mean_d = acc_sum_d[13:6];
  end

`ifdef ASCII_CELL_HYST_EN
  localparam logic [7:0] HYST_C = 8'(HYST);
  logic [7:0] diff_d;

  always_comb begin
    diff_d = (new_mean_d >= rd_data) ? (new_mean_d - rd_data) : (rd_data - new_mean_d);
    // Until a full frame exists the stored value is garbage, so always replace.
    take_d = !frame_ready_q || (diff_d > HYST_C);
  end
`else
  logic unused_ok;
  assign unused_ok = ^{rd_data[4:0], 8'(HYST)};
  assign take_d    = 1'b1;
`endif

  always_comb begin
    wr_en_d       = count_q && cell_end_q && take_d && !reset;
    frame_ready_d = frame_ready_q || (count_q && last_cell_q);
    cell_level_d  = frame_ready_q ? rd_data[7:5] : 3'd0;
  end

  // Only the column of the counted pixel moves; it clears on the cell's last pixel.
  for (genvar gi = 0; gi < CELLS_X; gi++) begin : g_acc
    assign acc_d[gi] = (count_q && (cx_q == CX_W'(gi)))
                       ? (cell_end_q ? 14'd0 : acc_sum_d)
                       : acc_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= 1'b0;
      cell_end_q    <= 1'b0;
      last_cell_q   <= 1'b0;
      de_q          <= 1'b0;
      luma_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      cx_q          <= '0;
      addr_q        <= '0;
      cell_level_q  <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_de_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      for (int i = 0; i < CELLS_X; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      count_q       <= count_d;
      cell_end_q    <= cell_end_d;
      last_cell_q   <= last_cell_d;
      de_q          <= de_d;
      luma_q        <= luma_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cx_q          <= cx_d;
      addr_q        <= rd_addr_d;
      cell_level_q  <= cell_level_d;
      out_x_q       <= x_q;
      out_y_q       <= y_q;
      out_de_q      <= de_q;
      frame_ready_q <= frame_ready_d;
      acc_q         <= acc_d;
    end
  end

  // Write lands on the stage-1 cell while the next pixel's read is issued;
  // read-first ordering keeps the displayed value from the previous frame.
  ascii_cell_ram #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .ADDR_W(ADDR_W)
  ) u_cell_ram (
    .clk    (clk),
    .wr_en  (wr_en_d),
    .wr_addr(addr_q),
    .wr_data(new_mean_d),
    .rd_addr(rd_addr_d),
    .rd_data(rd_data)
  );

  assign cell_level  = cell_level_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_de      = out_de_q;
  assign frame_ready = frame_ready_q;

endmodule
